// File: rtl/mtm_alu_deserializer.sv
// mtm_alu_deserializer: turns 11-bit serial frames on sin into 32-bit operands B/A and a 3-bit opcode.
// Frame order: start(0), type(0=DATA, 1=CMD), 8 payload bits MSB first, stop(1).
// Eight DATA frames then one CMD frame form a packet. The CMD frame carries {0, OP[2:0], CRC[3:0]}.
// Latency: t_valid/err_valid are registered SYNC_STAGES edges after the stop bit is sampled at the pin.
// There is no backpressure. Every result is a one-cycle pulse, and a/b/op/err_flags hold their value
// until the next pulse of the same kind.
// Ports:
//   clk, rst            : clock and asynchronous active-high reset
//   sin                 : serial input, idles high
//   a, b, op            : decoded operands and opcode, updated on t_valid
//   t_valid             : one-cycle pulse, packet accepted
//   err_valid           : one-cycle pulse, packet rejected
//   err_flags           : {err_data, err_crc, err_op}, one-hot, updated on err_valid
module mtm_alu_deserializer #(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sin,
  output logic [31:0] a,
  output logic [31:0] b,
  output logic [2:0]  op,
  output logic        t_valid,
  output logic        err_valid,
  output logic [2:0]  err_flags
);

  typedef enum logic [1:0] {IDLE, TYPE, PAYLOAD, STOP} state_t;

  // One CRC-4 (x^4+x+1) step, MSB-first bit-serial form.
  function automatic logic [3:0] crc_step(input logic [3:0] c, input logic d);
    logic fb;
    fb = c[3] ^ d;
    return {c[2:0], 1'b0} ^ {2'b00, fb, fb};
  endfunction

  // The chain resets to 0 so that a line held low through reset cannot arm the FSM.
  logic [SYNC_STAGES-1:0] sync;
  logic                   sin_s;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync <= '0;
    else     sync <= {sync[SYNC_STAGES-2:0], sin};
  end

  assign sin_s = sync[SYNC_STAGES-1];

  state_t      state;
  logic        armed;
  logic        is_cmd;
  logic [2:0]  bit_cnt;
  logic [7:0]  shreg;
  logic [3:0]  frame_cnt;
  logic [3:0]  crc;      // running CRC over the data payload bits of the current packet
  logic [63:0] stage;    // {B, A} staging, first byte received in [63:56]

  // Decode of the CMD payload. The CRC is closed over the trailing {1'b1, OP} bits.
  logic [2:0] op_rx;
  logic [3:0] crc_rx;
  logic [3:0] crc_calc;
  logic       op_ok;
  logic [2:0] byte_idx;

  always_comb begin
    op_rx    = shreg[6:4];
    crc_rx   = shreg[3:0];
    crc_calc = crc_step(crc, 1'b1);
    crc_calc = crc_step(crc_calc, op_rx[2]);
    crc_calc = crc_step(crc_calc, op_rx[1]);
    crc_calc = crc_step(crc_calc, op_rx[0]);
    case (op_rx)
      3'b000, 3'b001, 3'b100, 3'b101: op_ok = 1'b1;
      default:                        op_ok = 1'b0;
    endcase
    byte_idx = frame_cnt[2:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      armed     <= 1'b0;
      is_cmd    <= 1'b0;
      bit_cnt   <= '0;
      shreg     <= '0;
      frame_cnt <= '0;
      crc       <= '0;
      stage     <= '0;
      a         <= '0;
      b         <= '0;
      op        <= '0;
      t_valid   <= 1'b0;
      err_valid <= 1'b0;
      err_flags <= '0;
    end else begin
      t_valid   <= 1'b0;
      err_valid <= 1'b0;
      if (sin_s) armed <= 1'b1;

      case (state)
        IDLE: begin
          if (armed && !sin_s) state <= TYPE;
        end
        TYPE: begin
          is_cmd  <= sin_s;
          bit_cnt <= '0;
          state   <= PAYLOAD;
        end
        PAYLOAD: begin
          shreg <= {shreg[6:0], sin_s};
          // Only the first eight data bytes belong to the CRC. Any extra byte is an error anyway.
          if (!is_cmd && frame_cnt < 4'd8) crc <= crc_step(crc, sin_s);
          bit_cnt <= bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) state <= STOP;
        end
        STOP: begin
          // Back to IDLE at once, so a start bit right after the stop bit is caught.
          state <= IDLE;
          if (!sin_s) begin
            // Framing error: drop the packet and wait for a high line before the next start.
            err_valid <= 1'b1;
            err_flags <= 3'b100;
            frame_cnt <= '0;
            crc       <= '0;
            armed     <= 1'b0;
          end else if (!is_cmd) begin
            if (frame_cnt < 4'd8) stage[{~byte_idx, 3'b111} -: 8] <= shreg;
            if (frame_cnt != 4'd9) frame_cnt <= frame_cnt + 4'd1;
          end else begin
            frame_cnt <= '0;
            crc       <= '0;
            if (frame_cnt != 4'd8) begin
              err_valid <= 1'b1;
              err_flags <= 3'b100;
            end else if (crc_rx != crc_calc) begin
              err_valid <= 1'b1;
              err_flags <= 3'b010;
            end else if (!op_ok) begin
              err_valid <= 1'b1;
              err_flags <= 3'b001;
            end else begin
              b       <= stage[63:32];
              a       <= stage[31:0];
              op      <= op_rx;
              t_valid <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mtm_alu_deserializer.sv
// tb_mtm_alu_deserializer: directed self-checking bench for mtm_alu_deserializer.
// It drives frames bit by bit just after the rising edge and samples outputs on the falling edge.
// The CRC comes from a bit-serial model of the 68-bit message, except in one packet where it is hand-computed.
module tb_mtm_alu_deserializer;

  logic        clk = 1'b0;
  logic        rst;
  logic        sin;
  logic [31:0] a, b;
  logic [2:0]  op;
  logic        t_valid, err_valid;
  logic [2:0]  err_flags;

  mtm_alu_deserializer #(.SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .sin(sin), .a(a), .b(b), .op(op),
    .t_valid(t_valid), .err_valid(err_valid), .err_flags(err_flags)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  int tv_cnt = 0, ev_cnt = 0, both_cnt = 0;
  int tv_cyc = 0, tv_cyc_prev = 0;
  int stop_cyc = 0;

  always @(negedge clk) begin
    if (t_valid) begin
      tv_cnt      <= tv_cnt + 1;
      tv_cyc_prev <= tv_cyc;
      tv_cyc      <= cyc;
    end
    if (err_valid) ev_cnt <= ev_cnt + 1;
    if (t_valid && err_valid) both_cnt <= both_cnt + 1;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] crc4(input logic [31:0] bb, input logic [31:0] aa, input logic [2:0] oo);
    logic [67:0] m;
    logic [3:0]  c;
    logic        fb;
    m = {bb, aa, 1'b1, oo};
    c = 4'h0;
    for (int i = 67; i >= 0; i--) begin
      fb = c[3] ^ m[i];
      c  = {c[2:0], 1'b0};
      if (fb) c = c ^ 4'b0011;
    end
    return c;
  endfunction

  task automatic drive_bit(input logic v);
    sin = v;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    sin = 1'b1;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic frame(input logic t, input logic [7:0] d, input logic stop);
    drive_bit(1'b0);
    drive_bit(t);
    for (int i = 7; i >= 0; i--) drive_bit(d[i]);
    drive_bit(stop);
    stop_cyc = cyc;
  endtask

  task automatic data_frames(input logic [31:0] bb, input logic [31:0] aa, input int n);
    logic [63:0] m;
    m = {bb, aa};
    for (int i = 0; i < n; i++) frame(1'b0, m[63 - 8*i -: 8], 1'b1);
  endtask

  task automatic packet(input logic [31:0] bb, input logic [31:0] aa, input logic [2:0] oo,
                        input logic [3:0] crc_x, input int ndata);
    data_frames(bb, aa, ndata);
    frame(1'b1, {1'b0, oo, crc4(bb, aa, oo) ^ crc_x}, 1'b1);
  endtask

  int tv0, ev0;

  initial begin
    rst = 1'b1;
    sin = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_a", a, 0);
    chk("rst_b", b, 0);
    chk("rst_op", op, 0);
    chk("rst_tv", t_valid, 0);
    chk("rst_ev", err_valid, 0);
    chk("rst_flags", err_flags, 0);
    rst = 1'b0;
    idle(4);

    // Good ADD packet, latency of stop edge + 2.
    tv0 = tv_cnt; ev0 = ev_cnt;
    packet(32'h0000_0002, 32'h0000_0001, 3'b100, 4'h0, 8);
    idle(5);
    chk("add_tv_cnt", tv_cnt - tv0, 1);
    chk("add_ev_cnt", ev_cnt - ev0, 0);
    chk("add_latency", tv_cyc - stop_cyc, 2);
    chk("add_a", a, 32'h0000_0001);
    chk("add_b", b, 32'h0000_0002);
    chk("add_op", op, 3'b100);

    // Seven DATA frames only: a data error, and the outputs are held.
    tv0 = tv_cnt; ev0 = ev_cnt;
    packet(32'hDEAD_BEEF, 32'h1111_2222, 3'b000, 4'h0, 7);
    idle(5);
    chk("short_ev_cnt", ev_cnt - ev0, 1);
    chk("short_tv_cnt", tv_cnt - tv0, 0);
    chk("short_flags", err_flags, 3'b100);
    chk("short_a_held", a, 32'h0000_0001);
    chk("short_b_held", b, 32'h0000_0002);
    chk("short_op_held", op, 3'b100);
    tv0 = tv_cnt;
    packet(32'h1234_5678, 32'h9ABC_DEF0, 3'b000, 4'h0, 8);
    idle(5);
    chk("and_tv_cnt", tv_cnt - tv0, 1);
    chk("and_a", a, 32'h9ABC_DEF0);
    chk("and_b", b, 32'h1234_5678);
    chk("and_op", op, 3'b000);
    chk("flags_hold", err_flags, 3'b100);

    // CRC error, then an illegal opcode.
    ev0 = ev_cnt; tv0 = tv_cnt;
    packet(32'hAAAA_5555, 32'h0F0F_F0F0, 3'b101, 4'h1, 8);
    idle(5);
    chk("crc_ev_cnt", ev_cnt - ev0, 1);
    chk("crc_flags", err_flags, 3'b010);
    packet(32'hAAAA_5555, 32'h0F0F_F0F0, 3'b010, 4'h0, 8);
    idle(5);
    chk("opc_ev_cnt", ev_cnt - ev0, 2);
    chk("opc_flags", err_flags, 3'b001);
    chk("opc_tv_cnt", tv_cnt - tv0, 0);
    chk("opc_a_held", a, 32'h9ABC_DEF0);

    // Framing error, then the line held low for 20 cycles.
    ev0 = ev_cnt; tv0 = tv_cnt;
    frame(1'b0, 8'h55, 1'b0);
    for (int i = 0; i < 20; i++) drive_bit(1'b0);
    chk("frm_ev_cnt", ev_cnt - ev0, 1);
    chk("frm_flags", err_flags, 3'b100);
    chk("frm_tv_cnt", tv_cnt - tv0, 0);
    idle(4);
    // All-zero AND packet with a hand-computed CRC of 4'b1011.
    data_frames(32'h0, 32'h0, 8);
    frame(1'b1, 8'h0B, 1'b1);
    idle(5);
    chk("zero_tv_cnt", tv_cnt - tv0, 1);
    chk("zero_ev_cnt", ev_cnt - ev0, 1);
    chk("zero_a", a, 32'h0);
    chk("zero_b", b, 32'h0);

    // Reset during payload bit 4 of frame 5, released while the line is still low.
    packet(32'h7777_7777, 32'h3333_3333, 3'b001, 4'h0, 8);
    idle(5);
    tv0 = tv_cnt; ev0 = ev_cnt;
    data_frames(32'h1122_3344, 32'h5566_7788, 4);
    drive_bit(1'b0);
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(1'b0);
    sin = 1'b0;
    rst = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
    for (int i = 0; i < 12; i++) drive_bit(1'b0);
    chk("mrst_a", a, 0);
    chk("mrst_b", b, 0);
    chk("mrst_op", op, 0);
    chk("mrst_flags", err_flags, 0);
    chk("mrst_tv_cnt", tv_cnt - tv0, 0);
    chk("mrst_ev_cnt", ev_cnt - ev0, 0);
    idle(4);
    packet(32'h8000_0000, 32'hFFFF_FFFF, 3'b101, 4'h0, 8);
    idle(5);
    chk("sub_tv_cnt", tv_cnt - tv0, 1);
    chk("sub_a", a, 32'hFFFF_FFFF);
    chk("sub_b", b, 32'h8000_0000);
    chk("sub_op", op, 3'b101);

    // Two packets back to back: the pulses are 99 cycles apart.
    tv0 = tv_cnt; ev0 = ev_cnt;
    packet(32'h0F0F_0F0F, 32'h00FF_00FF, 3'b001, 4'h0, 8);
    packet(32'hCAFE_BABE, 32'h1357_2468, 3'b100, 4'h0, 8);
    idle(5);
    chk("b2b_tv_cnt", tv_cnt - tv0, 2);
    chk("b2b_ev_cnt", ev_cnt - ev0, 0);
    chk("b2b_spacing", tv_cyc - tv_cyc_prev, 99);
    chk("b2b_a", a, 32'h1357_2468);
    chk("b2b_b", b, 32'hCAFE_BABE);
    chk("b2b_op", op, 3'b100);

    chk("exclusive", both_cnt, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
